// File: rtl/avg_filter_pkg.sv
// Shared definitions for the AXI4-Lite moving-average filter: register map,
// bit positions, response codes and the runtime configuration struct.
package avg_filter_pkg;

    localparam logic [31:0] ADDR_CTRL   = 32'h00;
    localparam logic [31:0] ADDR_STATUS = 32'h04;
    localparam logic [31:0] ADDR_DIN    = 32'h08;
    localparam logic [31:0] ADDR_DOUT   = 32'h0C;
    localparam logic [31:0] ADDR_SUM    = 32'h10;

    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_SIGNED_BIT = 1;
    localparam int unsigned CTRL_LOG2_LSB   = 8;
    localparam int unsigned CTRL_CLEAR_BIT  = 31;

    localparam int unsigned STAT_OVALID_BIT = 0;
    localparam int unsigned STAT_FULL_BIT   = 1;
    localparam int unsigned STAT_OVR_BIT    = 2;
    localparam int unsigned STAT_FILL_LSB   = 8;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        SEL_CTRL,
        SEL_STATUS,
        SEL_DIN,
        SEL_DOUT,
        SEL_SUM,
        SEL_NONE
    } reg_sel_e;

    typedef struct packed {
        logic       enable;
        logic       is_signed;
        logic [2:0] log2_n;
    } ctrl_t;

    function automatic logic [2:0] sat_log2(input logic [2:0] v, input int unsigned max_v);
        if (32'(v) > max_v) return 3'(max_v);
        return v;
    endfunction

endpackage

// File: rtl/avg_filter_axil_if.sv
// AXI4-Lite bundle for the averaging filter; slave modport for the block,
// master modport for whoever drives it.
interface avg_filter_axil_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0]   AWADDR;
    logic                AWVALID;
    logic                AWREADY;
    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WVALID;
    logic                WREADY;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;
    logic [ADDR_W-1:0]   ARADDR;
    logic                ARVALID;
    logic                ARREADY;
    logic [DATA_W-1:0]   RDATA;
    logic [1:0]          RRESP;
    logic                RVALID;
    logic                RREADY;

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/avg_filter_core.sv
// Moving-average datapath: circular sample buffer, running sum and the
// registered average; one-cycle stage between push and result update.
module avg_filter_core
    import avg_filter_pkg::*;
#(
    parameter int unsigned SAMPLE_W   = 16,
    parameter int unsigned MAX_LOG2_N = 5,
    localparam int unsigned SUM_W     = SAMPLE_W + MAX_LOG2_N,
    localparam int unsigned DEPTH     = 1 << MAX_LOG2_N,
    localparam int unsigned FILL_W    = MAX_LOG2_N + 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                push_i,
    input  logic [SAMPLE_W-1:0] sample_i,
    input  logic                clear_i,
    input  logic                rd_clr_i,
    input  ctrl_t               cfg_i,
    output logic [SUM_W-1:0]    avg_o,
    output logic [SUM_W-1:0]    sum_o,
    output logic                out_valid_o,
    output logic [FILL_W-1:0]   fill_o,
    output logic                full_o,
    output logic                upd_o
);

    logic [SAMPLE_W-1:0]   mem_q [DEPTH];
    logic [MAX_LOG2_N-1:0] wp_q;
    logic [FILL_W-1:0]     fill_q;
    logic [SUM_W-1:0]      sum_q, sum_d;
    logic [SUM_W-1:0]      avg_q, avg_d;
    logic                  out_valid_q;
    logic                  s1_valid_q;
    logic [SAMPLE_W-1:0]   new_q, old_q;

    logic [FILL_W-1:0]     n_len;
    logic [MAX_LOG2_N-1:0] rd_idx;
    logic                  full;
    logic signed [SUM_W-1:0] sum_s;
    logic                  unused_cfg;

    assign unused_cfg = cfg_i.enable;

    function automatic logic [SUM_W-1:0] ext(input logic [SAMPLE_W-1:0] v, input logic sgn);
        return {{MAX_LOG2_N{sgn & v[SAMPLE_W-1]}}, v};
    endfunction

    always_comb begin
        n_len  = FILL_W'(1) << cfg_i.log2_n;
        full   = (fill_q >= n_len);
        // a window of the whole buffer wraps back onto wp itself
        rd_idx = wp_q - n_len[MAX_LOG2_N-1:0];
        sum_d  = sum_q + ext(new_q, cfg_i.is_signed) - ext(old_q, cfg_i.is_signed);
        sum_s  = sum_d;
        if (cfg_i.is_signed) avg_d = sum_s >>> cfg_i.log2_n;
        else                 avg_d = sum_d >> cfg_i.log2_n;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wp_q        <= '0;
            fill_q      <= '0;
            sum_q       <= '0;
            avg_q       <= '0;
            out_valid_q <= 1'b0;
            s1_valid_q  <= 1'b0;
            new_q       <= '0;
            old_q       <= '0;
        end else if (clear_i) begin
            wp_q        <= '0;
            fill_q      <= '0;
            sum_q       <= '0;
            avg_q       <= '0;
            out_valid_q <= 1'b0;
            s1_valid_q  <= 1'b0;
        end else begin
            s1_valid_q <= push_i;
            if (push_i) begin
                new_q <= sample_i;
                old_q <= full ? mem_q[rd_idx] : '0;
            end
            if (s1_valid_q) begin
                sum_q       <= sum_d;
                avg_q       <= avg_d;
                wp_q        <= wp_q + 1'b1;
                out_valid_q <= 1'b1;
                if (fill_q != FILL_W'(DEPTH)) fill_q <= fill_q + 1'b1;
            end else if (rd_clr_i) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (s1_valid_q) mem_q[wp_q] <= new_q;
    end

    assign avg_o       = avg_q;
    assign sum_o       = sum_q;
    assign out_valid_o = out_valid_q;
    assign fill_o      = fill_q;
    assign full_o      = full;
    assign upd_o       = s1_valid_q & ~clear_i;

endmodule

// File: rtl/avg_filter_axil.sv
// AXI4-Lite slave and register file wrapping the moving-average core;
// single outstanding transaction per channel, always OKAY.
module avg_filter_axil
    import avg_filter_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
    parameter int unsigned SAMPLE_W           = 16,
    parameter int unsigned MAX_LOG2_N         = 5
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    avg_filter_axil_if.slave  s_axi
);

    localparam int unsigned SUM_W  = SAMPLE_W + MAX_LOG2_N;
    localparam int unsigned FILL_W = MAX_LOG2_N + 1;

    logic                          awready_q, bvalid_q;
    logic                          arready_q, rvalid_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    ctrl_t                         ctrl_q, ctrl_d;
    logic                          clear_q, clear_d;
    logic                          push_q, push_d;
    logic [SAMPLE_W-1:0]           din_q;
    logic                          overrun_q;
    logic                          ovr_clr;

    logic                          wr_hs, ar_hs, rd_clr;
    reg_sel_e                      wsel, rsel;
    logic [SUM_W-1:0]              core_avg, core_sum;
    logic                          core_ovalid, core_full, core_upd;
    logic [FILL_W-1:0]             core_fill;
    logic                          unused_wdata;

    assign unused_wdata = ^s_axi.WDATA;

    function automatic reg_sel_e decode(input logic [C_S_AXI_ADDR_WIDTH-1:0] a);
        logic [31:0] w;
        w = 32'(a) & ~32'h3;
        case (w)
            ADDR_CTRL:   return SEL_CTRL;
            ADDR_STATUS: return SEL_STATUS;
            ADDR_DIN:    return SEL_DIN;
            ADDR_DOUT:   return SEL_DOUT;
            ADDR_SUM:    return SEL_SUM;
            default:     return SEL_NONE;
        endcase
    endfunction

    function automatic logic [31:0] ext32(input logic [SUM_W-1:0] v, input logic sgn);
        logic [63:0] w;
        w = {{(64-SUM_W){sgn & v[SUM_W-1]}}, v};
        return w[31:0];
    endfunction

    assign wr_hs  = awready_q & s_axi.AWVALID & s_axi.WVALID;
    assign ar_hs  = arready_q & s_axi.ARVALID;
    assign wsel   = decode(s_axi.AWADDR);
    assign rsel   = decode(s_axi.ARADDR);
    assign rd_clr = ar_hs & (rsel == SEL_DOUT);

    always_comb begin
        ctrl_d  = ctrl_q;
        clear_d = 1'b0;
        push_d  = 1'b0;
        ovr_clr = 1'b0;
        if (wr_hs) begin
            case (wsel)
                SEL_CTRL: begin
                    if (s_axi.WSTRB[0]) begin
                        ctrl_d.enable    = s_axi.WDATA[CTRL_EN_BIT];
                        ctrl_d.is_signed = s_axi.WDATA[CTRL_SIGNED_BIT];
                    end
                    if (s_axi.WSTRB[1])
                        ctrl_d.log2_n = sat_log2(s_axi.WDATA[CTRL_LOG2_LSB +: 3], MAX_LOG2_N);
                    clear_d = (s_axi.WSTRB[3] & s_axi.WDATA[CTRL_CLEAR_BIT])
                            | (ctrl_d.log2_n != ctrl_q.log2_n);
                end
                SEL_STATUS: ovr_clr = s_axi.WDATA[STAT_OVR_BIT];
                SEL_DIN:    push_d  = ctrl_q.enable;
                default:    ;
            endcase
        end
    end

    always_comb begin
        rdata_d = '0;
        case (rsel)
            SEL_CTRL: begin
                rdata_d[CTRL_EN_BIT]          = ctrl_q.enable;
                rdata_d[CTRL_SIGNED_BIT]      = ctrl_q.is_signed;
                rdata_d[CTRL_LOG2_LSB +: 3]   = ctrl_q.log2_n;
            end
            SEL_STATUS: begin
                rdata_d[STAT_OVALID_BIT]      = core_ovalid;
                rdata_d[STAT_FULL_BIT]        = core_full;
                rdata_d[STAT_OVR_BIT]         = overrun_q;
                rdata_d[STAT_FILL_LSB +: 8]   = 8'(core_fill);
            end
            SEL_DOUT: rdata_d = ext32(core_avg, ctrl_q.is_signed);
            SEL_SUM:  rdata_d = ext32(core_sum, ctrl_q.is_signed);
            default:  rdata_d = '0;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            ctrl_q    <= '0;
            clear_q   <= 1'b0;
            push_q    <= 1'b0;
            din_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            awready_q <= s_axi.AWVALID & s_axi.WVALID & ~bvalid_q & ~awready_q;
            if (wr_hs)              bvalid_q <= 1'b1;
            else if (s_axi.BREADY)  bvalid_q <= 1'b0;

            ctrl_q  <= ctrl_d;
            clear_q <= clear_d;
            push_q  <= push_d;
            if (push_d) din_q <= s_axi.WDATA[SAMPLE_W-1:0];

            // a fresh result landing on an unread one is an overrun; set beats W1C
            if (core_upd && core_ovalid) overrun_q <= 1'b1;
            else if (ovr_clr)            overrun_q <= 1'b0;

            arready_q <= s_axi.ARVALID & ~rvalid_q & ~arready_q;
            if (ar_hs)              rvalid_q <= 1'b1;
            else if (s_axi.RREADY)  rvalid_q <= 1'b0;
            if (ar_hs) rdata_q <= rdata_d;
        end
    end

    assign s_axi.AWREADY = awready_q;
    assign s_axi.WREADY  = awready_q;
    assign s_axi.BVALID  = bvalid_q;
    assign s_axi.BRESP   = RESP_OKAY;
    assign s_axi.ARREADY = arready_q;
    assign s_axi.RVALID  = rvalid_q;
    assign s_axi.RDATA   = rdata_q;
    assign s_axi.RRESP   = RESP_OKAY;

    avg_filter_core #(
        .SAMPLE_W   (SAMPLE_W),
        .MAX_LOG2_N (MAX_LOG2_N)
    ) u_core (
        .clk_i       (ACLK),
        .rst_ni      (ARESETN),
        .push_i      (push_q),
        .sample_i    (din_q),
        .clear_i     (clear_q),
        .rd_clr_i    (rd_clr),
        .cfg_i       (ctrl_q),
        .avg_o       (core_avg),
        .sum_o       (core_sum),
        .out_valid_o (core_ovalid),
        .fill_o      (core_fill),
        .full_o      (core_full),
        .upd_o       (core_upd)
    );

endmodule

// File: tb/tb_avg_filter_axil.sv
// Directed bench for avg_filter_axil: reads queue their expected word, a
// monitor pops and compares each read response as it appears on the bus.
module tb_avg_filter_axil;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int unsigned total = 0;
    int unsigned bad = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    always #5 clk = ~clk;

    avg_filter_axil_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    avg_filter_axil #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (5),
        .SAMPLE_W           (16),
        .MAX_LOG2_N         (5)
    ) dut (
        .ACLK    (clk),
        .ARESETN (rst_n),
        .s_axi   (bus)
    );

    always @(negedge clk) begin
        logic [31:0] e;
        string nm;
        if (bus.RVALID && bus.RREADY) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_read got=%08h", bus.RDATA);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (bus.RDATA !== e) begin
                    bad++;
                    $display("FAIL %s got=%08h exp=%08h", nm, bus.RDATA, e);
                end
            end
            total++;
            if (bus.RRESP !== 2'b00) begin
                bad++;
                $display("FAIL rresp got=%0d exp=0", bus.RRESP);
            end
        end
        if (bus.BVALID && bus.BREADY) begin
            total++;
            if (bus.BRESP !== 2'b00) begin
                bad++;
                $display("FAIL bresp got=%0d exp=0", bus.BRESP);
            end
        end
    end

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s_timeout got=no_handshake exp=handshake", nm);
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        int unsigned n;
        @(negedge clk);
        bus.AWADDR = a; bus.WDATA = d; bus.WSTRB = s;
        bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
        n = 0;
        while (!bus.AWREADY && n < 50) begin @(negedge clk); n++; end
        if (!bus.AWREADY) begin
            timeout("awready");
            bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
            return;
        end
        @(posedge clk);
        #1 bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.BVALID && n < 50) begin @(negedge clk); n++; end
        if (!bus.BVALID) timeout("bvalid");
        repeat (3) @(negedge clk);
    endtask

    task automatic axi_read(input logic [4:0] a, input logic [31:0] e, input string nm);
        int unsigned n;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
        bus.ARADDR = a; bus.ARVALID = 1'b1;
        n = 0;
        while (!bus.ARREADY && n < 50) begin @(negedge clk); n++; end
        if (!bus.ARREADY) begin
            timeout(nm);
            bus.ARVALID = 1'b0;
            void'(exp_q.pop_back());
            void'(name_q.pop_back());
            return;
        end
        @(posedge clk);
        #1 bus.ARVALID = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.RVALID && n < 50) begin @(negedge clk); n++; end
        if (!bus.RVALID) begin
            timeout(nm);
            void'(exp_q.pop_back());
            void'(name_q.pop_back());
        end
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] d);
        axi_write(5'h08, d, 4'hF);
    endtask

    initial begin
        int unsigned n;
        bus.AWADDR = '0; bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0;
        bus.WVALID = 1'b0; bus.BREADY = 1'b1; bus.ARADDR = '0; bus.ARVALID = 1'b0;
        bus.RREADY = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // reset state
        axi_read(5'h00, 32'h0, "rst_ctrl");
        axi_read(5'h04, 32'h0, "rst_status");
        axi_read(5'h0C, 32'h0, "rst_dout");
        axi_read(5'h10, 32'h0, "rst_sum");

        // N=4 unsigned average
        axi_write(5'h00, 32'h0000_0201, 4'hF);
        axi_read(5'h00, 32'h0000_0201, "ctrl_rb");
        push(32'd4);  axi_read(5'h0C, 32'd1,  "dout_p1");
        push(32'd8);  axi_read(5'h0C, 32'd3,  "dout_p2");
        push(32'd12); axi_read(5'h0C, 32'd6,  "dout_p3");
        push(32'd16); axi_read(5'h0C, 32'd10, "dout_p4");
        axi_read(5'h04, 32'h0000_0402, "status_full");
        push(32'd20);
        axi_read(5'h10, 32'd56, "sum_p5");
        axi_read(5'h0C, 32'd14, "dout_p5");

        // signed then unsigned with N=2
        axi_write(5'h00, 32'h0000_0103, 4'hF);
        push(32'h0000_FFF8);
        axi_read(5'h0C, 32'hFFFF_FFFC, "dout_signed");
        axi_read(5'h10, 32'hFFFF_FFF8, "sum_signed");
        axi_write(5'h00, 32'h8000_0101, 4'hF);
        push(32'h0000_FFF8);
        axi_read(5'h0C, 32'h0000_7FFC, "dout_unsigned");
        axi_read(5'h10, 32'h0000_FFF8, "sum_unsigned");

        // overrun and W1C
        push(32'd2);
        push(32'd4);
        axi_read(5'h04, 32'h0000_0307, "status_overrun");
        axi_write(5'h04, 32'h0000_0004, 4'hF);
        axi_read(5'h04, 32'h0000_0303, "status_w1c");
        axi_read(5'h0C, 32'd3, "dout_wrap");
        axi_read(5'h04, 32'h0000_0302, "status_after_rd");

        // clear via CTRL.clear
        push(32'd10);
        axi_read(5'h10, 32'd14, "sum_pre_clear");
        axi_write(5'h00, 32'h8000_0101, 4'hF);
        axi_read(5'h04, 32'h0, "status_clear");
        axi_read(5'h10, 32'h0, "sum_clear");
        axi_read(5'h0C, 32'h0, "dout_clear");

        // clear via log2_n change (saturating 7 -> 5); overrun survives
        push(32'd5);
        push(32'd7);
        axi_read(5'h10, 32'd12, "sum_pre_l2");
        axi_write(5'h00, 32'h0000_0701, 4'hF);
        axi_read(5'h00, 32'h0000_0501, "ctrl_sat");
        axi_read(5'h04, 32'h0000_0004, "status_l2clr");
        axi_read(5'h10, 32'h0, "sum_l2clr");

        // strobe gating: lane 0 only, log2_n untouched, enable off
        axi_write(5'h00, 32'h0000_0300, 4'h1);
        axi_read(5'h00, 32'h0000_0500, "ctrl_wstrb");
        push(32'd9);
        axi_read(5'h10, 32'h0, "sum_disabled");
        axi_read(5'h04, 32'h0000_0004, "status_disabled");

        // unmapped and write-only addresses
        axi_write(5'h1C, 32'hFFFF_FFFF, 4'hF);
        axi_read(5'h1C, 32'h0, "unmapped");
        axi_read(5'h08, 32'h0, "din_read");
        axi_read(5'h00, 32'h0000_0500, "ctrl_after_unmapped");

        // reset while BVALID pending
        bus.BREADY = 1'b0;
        @(negedge clk);
        bus.AWADDR = 5'h00; bus.WDATA = 32'h0000_0203; bus.WSTRB = 4'hF;
        bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
        n = 0;
        while (!bus.BVALID && n < 50) begin @(negedge clk); n++; end
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        total++;
        if (!bus.BVALID) begin
            bad++;
            $display("FAIL bvalid_pending got=0 exp=1");
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.BVALID !== 1'b0) begin
            bad++;
            $display("FAIL bvalid_in_reset got=%b exp=0", bus.BVALID);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bus.BREADY = 1'b1;
        @(negedge clk);
        axi_read(5'h00, 32'h0, "post_rst_ctrl");
        axi_read(5'h04, 32'h0, "post_rst_status");
        axi_read(5'h10, 32'h0, "post_rst_sum");
        axi_read(5'h0C, 32'h0, "post_rst_dout");

        repeat (4) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/avg_filter_axil.md
Name: avg_filter_axil

Overview:
Parametrised moving-average filter with an AXI4-Lite slave register interface. It is the successor of the fixed averaging IP.
- Software pushes samples through a register.
- The block keeps a circular sample buffer and a running sum.
- Window length (power of two), signedness and enable are runtime-configurable.
- Status, overrun detection and the raw sum are readable.
- Sits in the block design behind the AXI interconnect, clocked from the same ACLK.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width (fixed 32).
C_S_AXI_ADDR_WIDTH, 5, byte address width (8 word registers).
SAMPLE_W, 16, sample width, 2..32.
MAX_LOG2_N, 5, log2 of buffer depth; window N = 2^log2_n, log2_n in 0..MAX_LOG2_N.

Ports:
ACLK  in  1  clock, all logic on rising edge.
ARESETN  in  1  asynchronous active-low reset.
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write address handshake.
S_AXI_WDATA  in  32  write data.
S_AXI_WSTRB  in  4  byte strobes.
S_AXI_WVALID / S_AXI_WREADY  in/out  1  write data handshake.
S_AXI_BRESP  out  2  always OKAY.
S_AXI_BVALID / S_AXI_BREADY  out/in  1  write response handshake.
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read address handshake.
S_AXI_RDATA  out  32  read data.
S_AXI_RRESP  out  2  always OKAY.
S_AXI_RVALID / S_AXI_RREADY  out/in  1  read data handshake.

Behaviour:
Reset: every output is 0; all registers are 0; sum, fill count and write pointer are 0. Buffer RAM is not reset (fill count gates its use).

Write channel:
- AWREADY and WREADY pulse together for one cycle when AWVALID & WVALID & !BVALID.
- BVALID rises the next cycle and holds until BREADY.
- Back-to-back writes are therefore spaced at least 3 cycles apart.

Read channel:
- ARREADY pulses one cycle when ARVALID & !RVALID.
- RDATA is registered and RVALID rises the next cycle, holding until RREADY.

Addressing:
- Address bits [1:0] are ignored.
- Unmapped addresses read 0 and ignore writes, with OKAY response.
- WSTRB lanes gate CTRL writes only.
- DIN and STATUS writes act on the full word.

Register map:
- 0x00 CTRL (RW): [0] enable, [1] signed, [10:8] log2_n (values above MAX_LOG2_N saturate to MAX_LOG2_N), [31] clear (self-clearing, reads 0).
- 0x04 STATUS: [0] out_valid (RO), [1] window_full (RO, fill >= N), [2] overrun (W1C, sticky), [15:8] fill count (RO, saturates at 2^MAX_LOG2_N).
- 0x08 DIN (WO, reads 0): write pushes WDATA[SAMPLE_W-1:0] when enable=1; ignored when enable=0.
- 0x0C DOUT (RO): average, sign-extended if signed=1, else zero-extended. The handshake of a DOUT read clears out_valid.
- 0x10 SUM (RO): running sum, sign/zero-extended.

Clear conditions:
- A CTRL write with clear=1, or a CTRL write that changes log2_n, clears sum, fill count, write pointer, out_valid and DOUT in the cycle after the handshake.
- overrun is not cleared by these.

Filter pipeline (DIN handshake at edge T):
- T+1: new sample registered; oldest = buf[(wp - N) mod 2^MAX_LOG2_N] read if fill >= N, else 0.
- T+2:
  - sum <= sum + new - oldest; buf[wp] <= new; wp increments with wrap modulo 2^MAX_LOG2_N; fill increments (saturating).
  - DOUT <= (sum_next) >> log2_n, arithmetic shift if signed.
  - out_valid <= 1.
  - overrun set if out_valid was already 1.
- Latency from DIN handshake to DOUT valid: 2 cycles.

Arithmetic and edge cases:
- Sum width is SAMPLE_W + MAX_LOG2_N; it cannot overflow.
- Before the window fills, the divisor is still N (zero-padded start-up).
- DOUT read handshake in the same cycle as a result update: the update wins and out_valid stays 1.
- Toggling signed mid-stream does not clear; it affects only subsequent arithmetic and read extension.
- ARESETN asserted mid-transaction drops any pending AXI response and returns the block to reset state immediately.

Decomposition:
- Package avg_filter_pkg: register offsets, CTRL/STATUS bit-position constants, RESP_OKAY, and a ctrl_t struct (enable, is_signed, log2_n).
- Sub-module avg_filter_core: buffer, pointer, fill count, sum and DOUT pipeline. Its interface is push/sample/clear/cfg in and avg/sum/out_valid/fill out.
- The top level holds the AXI4-Lite slave and register file.

Test Plan:
1. Reset, then read 0x00/0x04/0x0C/0x10 -> all 0x00000000, RRESP=OKAY.
2. CTRL=0x00000201 (log2_n=2, enable, unsigned); push 4,8,12,16, reading DOUT after each -> DOUT=1,3,6,10. STATUS.window_full=1 after 4th push. Push 20 -> SUM=56, DOUT=14.
3. CTRL=0x00000103 (log2_n=1, signed); push 0xFFF8 -> DOUT=0xFFFFFFFC, SUM=0xFFFFFFF8. Repeat unsigned -> DOUT=0x00007FFC.
4. Push two samples without reading DOUT -> STATUS[2]=1. Write STATUS=0x4 -> STATUS[2]=0. out_valid is unaffected by the W1C.
5. Mid-stream CTRL write with clear=1, then separately with a log2_n change -> next STATUS read fill=0, out_valid=0; SUM=0.
6. Read/write 0x1C -> RDATA=0, BRESP/RRESP=OKAY, no state change. Assert ARESETN low during a pending BVALID -> BVALID=0 and all registers 0 after release.
